// File: rtl/needs_engine.sv
// needs_engine: produces the five pet need levels (hunger, happiness, health,
// hygiene, energy). Needs grow with game time and are reduced by care actions.
// The block also owns the alive/sleep/dead sequencing.
//
// Ports
//   clk_i          system clock
//   rst_ni         synchronous reset, active low
//   care_valid_i   care action request
//   care_action_i  0 FEED, 1 PLAY, 2 MEDICINE, 3 CLEAN, 4 SLEEP, 5-7 invalid
//   care_ready_o   an action can be accepted this cycle
//   care_err_o     1-cycle pulse after an invalid action code was accepted
//   hunger_o, happiness_o, health_o, hygiene_o, energy_o
//                  need levels 0..15 (15 is fatal)
//   tick_o         1-cycle game-tick pulse
//   sleeping_o     high while asleep
//   dead_o         high while dead
module needs_engine #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned HUNGER_PER  = 4,
  parameter int unsigned HAPPY_PER   = 6,
  parameter int unsigned HYGIENE_PER = 8,
  parameter int unsigned ENERGY_PER  = 5,
  parameter int unsigned HEALTH_PER  = 10,
  parameter int unsigned CARE_AMT    = 4,
  parameter int unsigned SLEEP_TICKS = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       care_valid_i,
  input  logic [2:0] care_action_i,
  output logic       care_ready_o,
  output logic       care_err_o,
  output logic [3:0] hunger_o,
  output logic [3:0] happiness_o,
  output logic [3:0] health_o,
  output logic [3:0] hygiene_o,
  output logic [3:0] energy_o,
  output logic       tick_o,
  output logic       sleeping_o,
  output logic       dead_o
);

  localparam int unsigned PRESC_W   = $clog2(TICK_DIV);
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NUM_NEEDS = 5;

  localparam int unsigned N_HUNGER  = 0;
  localparam int unsigned N_HAPPY   = 1;
  localparam int unsigned N_HEALTH  = 2;
  localparam int unsigned N_HYGIENE = 3;
  localparam int unsigned N_ENERGY  = 4;

  localparam logic [2:0] ACT_FEED     = 3'd0;
  localparam logic [2:0] ACT_PLAY     = 3'd1;
  localparam logic [2:0] ACT_MEDICINE = 3'd2;
  localparam logic [2:0] ACT_CLEAN    = 3'd3;
  localparam logic [2:0] ACT_SLEEP    = 3'd4;

  localparam logic [3:0] CARE_DEC  = 4'(CARE_AMT);
  localparam logic [3:0] NEED_MAX  = 4'd15;
  localparam logic [3:0] SICK_THR  = 4'd12;

  typedef enum logic [1:0] {
    ST_ALIVE = 2'd0,
    ST_SLEEP = 2'd1,
    ST_DEAD  = 2'd2
  } state_e;

  // Last count of each need's growth period counter.
  function automatic logic [CNT_W-1:0] per_last(input int unsigned idx);
    case (idx)
      N_HUNGER:  per_last = CNT_W'(HUNGER_PER - 1);
      N_HAPPY:   per_last = CNT_W'(HAPPY_PER - 1);
      N_HEALTH:  per_last = CNT_W'(HEALTH_PER - 1);
      N_HYGIENE: per_last = CNT_W'(HYGIENE_PER - 1);
      default:   per_last = CNT_W'(ENERGY_PER - 1);
    endcase
  endfunction

  // Net update clamped to 0..15; 6-bit signed keeps cur-dec+inc from wrapping.
  function automatic logic [3:0] apply_delta(input logic [3:0] cur,
                                             input logic [3:0] dec_amt,
                                             input logic [1:0] inc_amt);
    logic signed [5:0] sum;
    sum = $signed({2'b00, cur}) - $signed({2'b00, dec_amt}) + $signed({4'b0000, inc_amt});
    if (sum < 6'sd0) begin
      apply_delta = 4'd0;
    end else if (sum > 6'sd15) begin
      apply_delta = NEED_MAX;
    end else begin
      apply_delta = sum[3:0];
    end
  endfunction

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                tick_q, tick_d;
  logic [CNT_W-1:0]    per_q   [NUM_NEEDS];
  logic [CNT_W-1:0]    per_d   [NUM_NEEDS];
  logic [CNT_W-1:0]    sleep_q, sleep_d;
  logic [3:0]          need_q  [NUM_NEEDS];
  logic [3:0]          need_d  [NUM_NEEDS];
  logic [3:0]          need_dec[NUM_NEEDS];
  logic [1:0]          need_inc[NUM_NEEDS];
  logic                err_q, err_d;
  logic                ready_q, sleeping_q, dead_q;
  logic                accept;
  logic                fatal;

  // Next-state, need arithmetic and tick generation.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    sleep_d = sleep_q;
    err_d   = 1'b0;
    accept  = care_valid_i && ready_q;
    fatal   = 1'b0;
    for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
      per_d[i]    = per_q[i];
      need_d[i]   = need_q[i];
      need_dec[i] = 4'd0;
      need_inc[i] = 2'd0;
      if (need_q[i] == NEED_MAX) begin
        fatal = 1'b1;
      end
    end

    case (state_q)
      ST_ALIVE: begin
        if (accept) begin
          case (care_action_i)
            ACT_FEED: begin
              need_dec[N_HUNGER]  = CARE_DEC;
              need_inc[N_HYGIENE] = 2'd1;
            end
            ACT_PLAY: begin
              need_dec[N_HAPPY]  = CARE_DEC;
              need_inc[N_ENERGY] = 2'd1;
            end
            ACT_MEDICINE: need_dec[N_HEALTH]  = CARE_DEC;
            ACT_CLEAN:    need_dec[N_HYGIENE] = CARE_DEC;
            ACT_SLEEP: begin
              state_d = ST_SLEEP;
              sleep_d = '0;
            end
            default:      err_d = 1'b1;
          endcase
        end
      end
      ST_SLEEP: begin
        // Rest recovers one energy per tick; wake after SLEEP_TICKS ticks.
        if (tick_q) begin
          need_dec[N_ENERGY] = 4'd1;
          if (sleep_q == CNT_W'(SLEEP_TICKS - 1)) begin
            state_d = ST_ALIVE;
            sleep_d = '0;
          end else begin
            sleep_d = sleep_q + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase

    // Everything freezes in DEAD, including the prescaler.
    if (state_q != ST_DEAD) begin
      tick_d  = (presc_q == PRESC_W'(TICK_DIV - 1));
      presc_d = tick_d ? '0 : presc_q + PRESC_W'(1);

      if (tick_q) begin
        for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
          if (per_q[i] == per_last(i)) begin
            per_d[i] = '0;
            // Fatigue does not build up while asleep.
            if (!((i == N_ENERGY) && (state_q == ST_SLEEP))) begin
              need_inc[i] = need_inc[i] + 2'd1;
            end
          end else begin
            per_d[i] = per_q[i] + CNT_W'(1);
          end
        end
        // Starvation or filth makes the pet sicker on every tick.
        if ((need_q[N_HUNGER] >= SICK_THR) || (need_q[N_HYGIENE] >= SICK_THR)) begin
          need_inc[N_HEALTH] = need_inc[N_HEALTH] + 2'd1;
        end
      end

      for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
        need_d[i] = apply_delta(need_q[i], need_dec[i], need_inc[i]);
      end

      // Death wins over waking up.
      if (fatal) begin
        state_d = ST_DEAD;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_ALIVE;
      presc_q    <= '0;
      tick_q     <= 1'b0;
      sleep_q    <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
      sleeping_q <= 1'b0;
      dead_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
        per_q[i]  <= '0;
        need_q[i] <= 4'd0;
      end
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      sleep_q    <= sleep_d;
      err_q      <= err_d;
      ready_q    <= (state_d == ST_ALIVE);
      sleeping_q <= (state_d == ST_SLEEP);
      dead_q     <= (state_d == ST_DEAD);
      for (int unsigned i = 0; i < NUM_NEEDS; i++) begin
        per_q[i]  <= per_d[i];
        need_q[i] <= need_d[i];
      end
    end
  end

  assign care_ready_o = ready_q;
  assign care_err_o   = err_q;
  assign hunger_o     = need_q[N_HUNGER];
  assign happiness_o  = need_q[N_HAPPY];
  assign health_o     = need_q[N_HEALTH];
  assign hygiene_o    = need_q[N_HYGIENE];
  assign energy_o     = need_q[N_ENERGY];
  assign tick_o       = tick_q;
  assign sleeping_o   = sleeping_q;
  assign dead_o       = dead_q;

endmodule

// File: tb/tb_needs_engine.sv
// Testbench for needs_engine: directed scenarios plus random care traffic,
// every output compared each cycle against a tick-counting reference model.
module tb_needs_engine;

  localparam int TICK_DIV    = 4;
  localparam int CARE_AMT    = 4;
  localparam int SLEEP_TICKS = 2;

  localparam logic [2:0] FEED = 3'd0;
  localparam logic [2:0] MEDICINE = 3'd2;
  localparam logic [2:0] SLEEP = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       care_valid;
  logic [2:0] care_action;
  logic       care_ready, care_err, tick, sleeping, dead;
  logic [3:0] hunger, happiness, health, hygiene, energy;

  always #5 clk = ~clk;

  needs_engine #(
    .TICK_DIV(4), .HUNGER_PER(2), .HAPPY_PER(3), .HYGIENE_PER(3),
    .ENERGY_PER(3), .HEALTH_PER(3), .CARE_AMT(4), .SLEEP_TICKS(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .care_valid_i(care_valid), .care_action_i(care_action),
    .care_ready_o(care_ready), .care_err_o(care_err),
    .hunger_o(hunger), .happiness_o(happiness), .health_o(health),
    .hygiene_o(hygiene), .energy_o(energy),
    .tick_o(tick), .sleeping_o(sleeping), .dead_o(dead)
  );

  // Reference model: needs indexed hunger, happiness, health, hygiene, energy.
  // Mode 0 alive, 1 asleep, 2 dead. Growth happens on the k-th game tick
  // whenever k is a multiple of that need's period.
  int m_need[5];
  int m_per[5] = '{2, 3, 3, 3, 3};
  int m_mode, m_edges, m_ticks, m_sleep;
  bit m_tick, m_err;

  int n_assert = 0;
  int n_fail   = 0;

  function automatic int clamp15(input int v);
    if (v < 0) return 0;
    if (v > 15) return 15;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_need[i] = 0;
    m_mode = 0; m_edges = 0; m_ticks = 0; m_sleep = 0;
    m_tick = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int a);
    int d[5];
    bit fatal;
    int nmode;
    for (int i = 0; i < 5; i++) d[i] = 0;
    if (m_mode == 2) begin
      m_err = 0;
      m_tick = 0;
      return;
    end
    fatal = 0;
    for (int i = 0; i < 5; i++) if (m_need[i] == 15) fatal = 1;
    nmode = m_mode;
    m_err = 0;
    if (m_tick) begin
      m_ticks++;
      for (int i = 0; i < 5; i++)
        if ((m_ticks % m_per[i] == 0) && !(i == 4 && m_mode == 1)) d[i]++;
      if (m_need[0] >= 12 || m_need[3] >= 12) d[2]++;
      if (m_mode == 1) begin
        d[4]--;
        m_sleep++;
        if (m_sleep == SLEEP_TICKS) nmode = 0;
      end
    end
    if (v && m_mode == 0) begin
      case (a)
        0: begin d[0] -= CARE_AMT; d[3]++; end
        1: begin d[1] -= CARE_AMT; d[4]++; end
        2: d[2] -= CARE_AMT;
        3: d[3] -= CARE_AMT;
        4: begin nmode = 1; m_sleep = 0; end
        default: m_err = 1;
      endcase
    end
    for (int i = 0; i < 5; i++) m_need[i] = clamp15(m_need[i] + d[i]);
    if (fatal) nmode = 2;
    m_mode = nmode;
    m_edges++;
    m_tick = (m_edges % TICK_DIV == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hunger",    32'(hunger),    32'(m_need[0]));
    chk("happiness", 32'(happiness), 32'(m_need[1]));
    chk("health",    32'(health),    32'(m_need[2]));
    chk("hygiene",   32'(hygiene),   32'(m_need[3]));
    chk("energy",    32'(energy),    32'(m_need[4]));
    chk("tick",      32'(tick),      32'(m_tick));
    chk("care_err",  32'(care_err),  32'(m_err));
    chk("ready",     32'(care_ready), 32'(m_mode == 0));
    chk("sleeping",  32'(sleeping),  32'(m_mode == 1));
    chk("dead",      32'(dead),      32'(m_mode == 2));
  endtask

  // One clock: drive, let the edge happen, then compare on the falling edge.
  task automatic step(input bit v, input logic [2:0] a);
    care_valid  = v;
    care_action = a;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, int'(a));
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 3'd0);
    step(1'b0, 3'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int hyg_before;
    rst_n = 1'b0;
    care_valid = 1'b0;
    care_action = 3'd0;
    model_reset();

    // Reset state and tick cadence.
    do_reset();
    chk("rst_ready", 32'(care_ready), 32'd1);
    chk("rst_hunger", 32'(hunger), 32'd0);
    repeat (9) step(1'b0, 3'd0);
    chk("hunger_after_tick2", 32'(hunger), 32'd1);
    repeat (8) step(1'b0, 3'd0);
    chk("hunger_after_tick4", 32'(hunger), 32'd2);

    // FEED at hunger 2 floors at zero and dirties the pet.
    hyg_before = m_need[3];
    step(1'b1, FEED);
    chk("feed_floor", 32'(hunger), 32'd0);
    chk("feed_hygiene", 32'(hygiene), 32'(hyg_before + 1));
    chk("feed_no_err", 32'(care_err), 32'd0);

    // FEED on the same edge as a hunger growth at hunger 5: net -3.
    do_reset();
    cnt = 0;
    while (!(m_need[0] == 5 && m_tick && ((m_ticks + 1) % 2 == 0)) && cnt < 400) begin
      step(1'b0, 3'd0);
      cnt++;
    end
    chk("wait_hunger5_bound", 32'(cnt < 400), 32'd1);
    step(1'b1, FEED);
    chk("feed_net", 32'(hunger), 32'd2);

    // SLEEP at energy 3: two ticks of rest leave energy 1.
    do_reset();
    cnt = 0;
    while (m_need[4] != 3 && cnt < 400) begin
      step(1'b0, 3'd0);
      cnt++;
    end
    chk("wait_energy3_bound", 32'(cnt < 400), 32'd1);
    step(1'b1, SLEEP);
    chk("sleep_ready", 32'(care_ready), 32'd0);
    chk("sleep_flag", 32'(sleeping), 32'd1);
    cnt = 0;
    while (m_mode == 1 && cnt < 100) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      cnt++;
    end
    chk("wake_bound", 32'(cnt < 100), 32'd1);
    chk("wake_energy", 32'(energy), 32'd1);
    chk("wake_ready", 32'(care_ready), 32'd1);

    // Invalid action code: one-cycle error pulse.
    step(1'b1, 3'd6);
    chk("err_pulse", 32'(care_err), 32'd1);
    step(1'b0, 3'd0);
    chk("err_clear", 32'(care_err), 32'd0);

    // Random care traffic with occasional resets.
    do_reset();
    repeat (400) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    // Starve to death while keeping health down with medicine.
    do_reset();
    cnt = 0;
    while (m_mode != 2 && cnt < 1000) begin
      step(m_need[2] >= 10, MEDICINE);
      cnt++;
    end
    chk("death_bound", 32'(cnt < 1000), 32'd1);
    chk("death_flag", 32'(dead), 32'd1);
    chk("death_ready", 32'(care_ready), 32'd0);
    chk("death_hunger", 32'(hunger), 32'd15);
    repeat (12) step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    chk("frozen_hunger", 32'(hunger), 32'd15);
    do_reset();
    chk("revive_dead", 32'(dead), 32'd0);
    chk("revive_ready", 32'(care_ready), 32'd1);
    chk("revive_hunger", 32'(hunger), 32'd0);
    repeat (6) step(1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
